// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the two-requester memory port arbiter.
// Holds the FSM state encoding, default latency and the tie-break helper.
package mem_port_arbiter_pkg;

    localparam int DATA_W          = 32;
    localparam int DEFAULT_MEM_LAT = 2;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arbState_t;

    // A tie goes to whoever did not win last time; otherwise the sole requester wins.
    function automatic logic pickWinner(input logic eff0, input logic eff1, input logic last);
        return (eff0 & eff1) ? ~last : eff1;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester handshakes and memory port signals around the arbiter.
// The slave modport is the arbiter; the master modport is requesters plus memory.
interface mem_port_arbiter_if;
    import mem_port_arbiter_pkg::*;

    logic              req0, req1;
    logic [DATA_W-1:0] addr0, addr1;
    logic [DATA_W-1:0] wdata0, wdata1;
    logic              we0, we1;
    logic              gnt0, gnt1;
    logic              done0, done1;
    logic [DATA_W-1:0] rdata;
    logic              sel;
    logic              mem_en, mem_we;
    logic [DATA_W-1:0] mem_addr, mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  req0, req1, addr0, addr1, wdata0, wdata1, we0, we1, mem_rdata,
        output gnt0, gnt1, done0, done1, rdata, sel, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req0, req1, addr0, addr1, wdata0, wdata1, we0, we1, mem_rdata,
        input  gnt0, gnt1, done0, done1, rdata, sel, mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_port_arbiter_mux.sv
// 32-bit two-input mux used to steer address and write data onto the memory port.
module mux2x1_32bit
    import mem_port_arbiter_pkg::*;
(
    input  logic              i_sel,
    input  logic [DATA_W-1:0] i_in0,
    input  logic [DATA_W-1:0] i_in1,
    output logic [DATA_W-1:0] o_out
);

    assign o_out = i_sel ? i_in1 : i_in0;

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch (0) and data (1).
// Each access holds mem_en for MEM_LAT cycles; gnt and done are single-cycle pulses.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int MEM_LAT = DEFAULT_MEM_LAT,
    parameter int CNT_W   = 4
)
(
    input  logic          clk,
    input  logic          reset,
    mem_port_arbiter_if.slave bus
);

    arbState_t         r_state, w_nextState;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_last, r_sel;
    logic              r_gnt0, r_gnt1, r_done0, r_done1;
    logic [DATA_W-1:0] r_rdata;
    logic              w_eff0, w_eff1, w_start, w_winner, w_finish, w_weSel;
    logic [DATA_W-1:0] w_addr, w_wdata;

    assign w_weSel = r_sel ? bus.we1 : bus.we0;

    // A requester is masked in its own done cycle so it cannot be re-granted straight away.
    always_comb begin
        w_nextState = r_state;
        w_eff0      = 1'b0;
        w_eff1      = 1'b0;
        w_winner    = r_sel;
        w_start     = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            IDLE: begin
                w_eff0   = bus.req0 & ~r_done0;
                w_eff1   = bus.req1 & ~r_done1;
                w_winner = pickWinner(w_eff0, w_eff1, r_last);
                w_start  = w_eff0 | w_eff1;
                if (w_start) w_nextState = BUSY;
            end
            BUSY: begin
                w_finish = (r_cnt == '0);
                if (w_finish) w_nextState = IDLE;
            end
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_nextState;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt   <= '0;
            r_last  <= 1'b1;
            r_sel   <= 1'b0;
            r_gnt0  <= 1'b0;
            r_gnt1  <= 1'b0;
            r_done0 <= 1'b0;
            r_done1 <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_gnt0  <= w_start & ~w_winner;
            r_gnt1  <= w_start &  w_winner;
            r_done0 <= w_finish & ~r_sel;
            r_done1 <= w_finish &  r_sel;
            if (w_start) begin
                r_sel  <= w_winner;
                r_last <= w_winner;
                r_cnt  <= CNT_W'(MEM_LAT - 1);
            end else if ((r_state == BUSY) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_finish && !w_weSel) r_rdata <= bus.mem_rdata;
        end
    end

    mux2x1_32bit u_addrMux (
        .i_sel (r_sel),
        .i_in0 (bus.addr0),
        .i_in1 (bus.addr1),
        .o_out (w_addr)
    );

    mux2x1_32bit u_wdataMux (
        .i_sel (r_sel),
        .i_in0 (bus.wdata0),
        .i_in1 (bus.wdata1),
        .o_out (w_wdata)
    );

    assign bus.gnt0      = r_gnt0;
    assign bus.gnt1      = r_gnt1;
    assign bus.done0     = r_done0;
    assign bus.done1     = r_done1;
    assign bus.rdata     = r_rdata;
    assign bus.sel       = r_sel;
    assign bus.mem_en    = (r_state == BUSY);
    assign bus.mem_we    = (r_state == BUSY) & w_weSel;
    assign bus.mem_addr  = w_addr;
    assign bus.mem_wdata = w_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a MEM_LAT=2 instance for most scenarios
// and a MEM_LAT=1 instance for the back-to-back throughput case.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam logic [31:0] MASK = 32'h5A5A_0000;

    typedef struct {
        logic        who;
        logic [31:0] data;
    } exp_t;

    logic clk;
    logic reset;
    logic useFixed;
    logic [31:0] fixedData;
    int total;
    int bad;
    exp_t doneQ[$];
    logic gntQ[$];

    mem_port_arbiter_if ifcA ();
    mem_port_arbiter_if ifcB ();

    mem_port_arbiter #(.MEM_LAT(2), .CNT_W(4)) dutA (
        .clk   (clk),
        .reset (reset),
        .bus   (ifcA)
    );

    mem_port_arbiter #(.MEM_LAT(1), .CNT_W(4)) dutB (
        .clk   (clk),
        .reset (reset),
        .bus   (ifcB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Simple memory model: a fixed value when a test needs one, else address-derived data.
    always_comb ifcA.mem_rdata = useFixed ? fixedData : (ifcA.mem_addr ^ MASK);
    always_comb ifcB.mem_rdata = ifcB.mem_addr ^ MASK;

    task automatic clearInputs;
        ifcA.req0 = 1'b0; ifcA.req1 = 1'b0; ifcA.we0 = 1'b0; ifcA.we1 = 1'b0;
        ifcA.addr0 = '0; ifcA.addr1 = '0; ifcA.wdata0 = '0; ifcA.wdata1 = '0;
        ifcB.req0 = 1'b0; ifcB.req1 = 1'b0; ifcB.we0 = 1'b0; ifcB.we1 = 1'b0;
        ifcB.addr0 = '0; ifcB.addr1 = '0; ifcB.wdata0 = '0; ifcB.wdata1 = '0;
        doneQ.delete();
        gntQ.delete();
    endtask

    task automatic doReset;
        reset = 1'b1;
        clearInputs();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        clearInputs();
        repeat (2) @(negedge clk);
        total++;
        if ({ifcA.gnt0, ifcA.gnt1, ifcA.done0, ifcA.done1, ifcA.mem_en, ifcA.mem_we, ifcA.sel} !== 7'b0) begin
            bad++;
            $display("[TB] FAIL reset_ctrl_A got=%b want=0000000",
                     {ifcA.gnt0, ifcA.gnt1, ifcA.done0, ifcA.done1, ifcA.mem_en, ifcA.mem_we, ifcA.sel});
        end
        total++;
        if (ifcA.rdata !== 32'h0) begin
            bad++;
            $display("[TB] FAIL reset_rdata_A got=%h want=00000000", ifcA.rdata);
        end
        total++;
        if ({ifcB.gnt0, ifcB.gnt1, ifcB.done0, ifcB.done1, ifcB.mem_en, ifcB.mem_we, ifcB.sel} !== 7'b0) begin
            bad++;
            $display("[TB] FAIL reset_ctrl_B got=%b want=0000000",
                     {ifcB.gnt0, ifcB.gnt1, ifcB.done0, ifcB.done1, ifcB.mem_en, ifcB.mem_we, ifcB.sel});
        end
        reset = 1'b0;
        @(negedge clk);
        ifcA.addr0 = 32'h10; ifcA.addr1 = 32'h20;
        ifcA.req0 = 1'b1; ifcA.req1 = 1'b1;
        @(negedge clk);
        total++;
        if ({ifcA.gnt0, ifcA.gnt1, ifcA.sel} !== 3'b100) begin
            bad++;
            $display("[TB] FAIL first_tie gnt0,gnt1,sel got=%b want=100", {ifcA.gnt0, ifcA.gnt1, ifcA.sel});
        end
        total++;
        if (ifcA.mem_addr !== 32'h10) begin
            bad++;
            $display("[TB] FAIL first_tie_addr got=%h want=00000010", ifcA.mem_addr);
        end
        doReset();
    endtask

    task automatic test_read;
        exp_t e;
        useFixed = 1'b1;
        fixedData = 32'hAAAA_AAAA;
        ifcA.addr0 = 32'h0000_0040; ifcA.we0 = 1'b0; ifcA.req0 = 1'b1;
        doneQ.push_back('{1'b0, 32'hAAAA_AAAA});
        @(negedge clk);
        total++;
        if ({ifcA.gnt0, ifcA.gnt1, ifcA.mem_en, ifcA.mem_we} !== 4'b1010 || ifcA.mem_addr !== 32'h40) begin
            bad++;
            $display("[TB] FAIL read_c1 gnt0,gnt1,en,we got=%b addr=%h want=1010 addr=00000040",
                     {ifcA.gnt0, ifcA.gnt1, ifcA.mem_en, ifcA.mem_we}, ifcA.mem_addr);
        end
        @(negedge clk);
        total++;
        if ({ifcA.gnt0, ifcA.mem_en, ifcA.done0} !== 3'b010 || ifcA.mem_addr !== 32'h40) begin
            bad++;
            $display("[TB] FAIL read_c2 gnt0,en,done0 got=%b addr=%h want=010 addr=00000040",
                     {ifcA.gnt0, ifcA.mem_en, ifcA.done0}, ifcA.mem_addr);
        end
        @(negedge clk);
        total++;
        if ({ifcA.done0, ifcA.done1, ifcA.mem_en} !== 3'b100) begin
            bad++;
            $display("[TB] FAIL read_done done0,done1,en got=%b want=100", {ifcA.done0, ifcA.done1, ifcA.mem_en});
        end
        total++;
        if (doneQ.size() == 0) begin
            bad++;
            $display("[TB] FAIL read_sb got=empty want=entry");
        end else begin
            e = doneQ.pop_front();
            if (ifcA.rdata !== e.data) begin
                bad++;
                $display("[TB] FAIL read_rdata got=%h want=%h", ifcA.rdata, e.data);
            end
        end
        ifcA.req0 = 1'b0;
    endtask

    task automatic test_write;
        exp_t e;
        @(negedge clk);
        fixedData = 32'hBBBB_BBBB;
        ifcA.addr1 = 32'h80; ifcA.wdata1 = 32'h1111_1111; ifcA.we1 = 1'b1; ifcA.req1 = 1'b1;
        doneQ.push_back('{1'b1, 32'hAAAA_AAAA});
        @(negedge clk);
        total++;
        if ({ifcA.gnt1, ifcA.sel, ifcA.mem_en, ifcA.mem_we} !== 4'b1111 ||
            ifcA.mem_wdata !== 32'h1111_1111 || ifcA.mem_addr !== 32'h80) begin
            bad++;
            $display("[TB] FAIL write_c1 gnt1,sel,en,we got=%b wdata=%h addr=%h want=1111 wdata=11111111 addr=00000080",
                     {ifcA.gnt1, ifcA.sel, ifcA.mem_en, ifcA.mem_we}, ifcA.mem_wdata, ifcA.mem_addr);
        end
        @(negedge clk);
        total++;
        if ({ifcA.gnt1, ifcA.mem_en, ifcA.mem_we} !== 3'b011 || ifcA.mem_wdata !== 32'h1111_1111) begin
            bad++;
            $display("[TB] FAIL write_c2 gnt1,en,we got=%b wdata=%h want=011 wdata=11111111",
                     {ifcA.gnt1, ifcA.mem_en, ifcA.mem_we}, ifcA.mem_wdata);
        end
        @(negedge clk);
        total++;
        if ({ifcA.done1, ifcA.done0, ifcA.mem_en, ifcA.mem_we} !== 4'b1000) begin
            bad++;
            $display("[TB] FAIL write_done done1,done0,en,we got=%b want=1000",
                     {ifcA.done1, ifcA.done0, ifcA.mem_en, ifcA.mem_we});
        end
        total++;
        if (doneQ.size() == 0) begin
            bad++;
            $display("[TB] FAIL write_sb got=empty want=entry");
        end else begin
            e = doneQ.pop_front();
            if (ifcA.rdata !== e.data) begin
                bad++;
                $display("[TB] FAIL write_rdata_hold got=%h want=%h", ifcA.rdata, e.data);
            end
        end
        ifcA.req1 = 1'b0; ifcA.we1 = 1'b0;
    endtask

    task automatic test_reset_mid_busy;
        @(negedge clk);
        ifcA.addr0 = 32'h40; ifcA.we0 = 1'b0; ifcA.req0 = 1'b1;
        @(negedge clk);
        total++;
        if (ifcA.mem_en !== 1'b1) begin
            bad++;
            $display("[TB] FAIL midbusy_en got=%b want=1", ifcA.mem_en);
        end
        #2 reset = 1'b1;
        #1;
        total++;
        if ({ifcA.gnt0, ifcA.gnt1, ifcA.done0, ifcA.done1, ifcA.mem_en, ifcA.mem_we, ifcA.sel} !== 7'b0) begin
            bad++;
            $display("[TB] FAIL midbusy_async_ctrl got=%b want=0000000",
                     {ifcA.gnt0, ifcA.gnt1, ifcA.done0, ifcA.done1, ifcA.mem_en, ifcA.mem_we, ifcA.sel});
        end
        total++;
        if (ifcA.rdata !== 32'h0) begin
            bad++;
            $display("[TB] FAIL midbusy_async_rdata got=%h want=00000000", ifcA.rdata);
        end
        ifcA.addr1 = 32'h44; ifcA.req1 = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        total++;
        if ({ifcA.gnt0, ifcA.gnt1, ifcA.sel} !== 3'b100) begin
            bad++;
            $display("[TB] FAIL midbusy_tie gnt0,gnt1,sel got=%b want=100", {ifcA.gnt0, ifcA.gnt1, ifcA.sel});
        end
        doReset();
    endtask

    task automatic test_alternate;
        exp_t e;
        logic w;
        int dones;
        useFixed = 1'b0;
        ifcA.addr0 = 32'h100; ifcA.addr1 = 32'h200;
        ifcA.req0 = 1'b1; ifcA.req1 = 1'b1;
        for (int k = 0; k < 6; k++) begin
            gntQ.push_back(k[0]);
            doneQ.push_back('{k[0], (k[0] ? 32'h200 : 32'h100) ^ MASK});
        end
        dones = 0;
        for (int c = 0; c < 40 && dones < 6; c++) begin
            @(negedge clk);
            if (ifcA.gnt0 || ifcA.gnt1) begin
                total++;
                if (gntQ.size() == 0) begin
                    bad++;
                    $display("[TB] FAIL alt_extra_gnt got=%b want=none", {ifcA.gnt1, ifcA.gnt0});
                end else begin
                    w = gntQ.pop_front();
                    if ({ifcA.gnt1, ifcA.gnt0, ifcA.sel} !== {w, ~w, w}) begin
                        bad++;
                        $display("[TB] FAIL alt_gnt gnt1,gnt0,sel got=%b want=%b",
                                 {ifcA.gnt1, ifcA.gnt0, ifcA.sel}, {w, ~w, w});
                    end
                end
            end
            if (ifcA.done0 || ifcA.done1) begin
                total++;
                dones++;
                if (doneQ.size() == 0) begin
                    bad++;
                    $display("[TB] FAIL alt_extra_done got=%b want=none", {ifcA.done1, ifcA.done0});
                end else begin
                    e = doneQ.pop_front();
                    if ({ifcA.done1, ifcA.done0} !== {e.who, ~e.who} || ifcA.rdata !== e.data) begin
                        bad++;
                        $display("[TB] FAIL alt_done done1,done0=%b rdata=%h want=%b rdata=%h",
                                 {ifcA.done1, ifcA.done0}, ifcA.rdata, {e.who, ~e.who}, e.data);
                    end
                end
                if (dones == 6) begin
                    ifcA.req0 = 1'b0; ifcA.req1 = 1'b0;
                end
            end
        end
        total++;
        if (dones != 6 || gntQ.size() != 0) begin
            bad++;
            $display("[TB] FAIL alt_count dones=%0d gntLeft=%0d want dones=6 gntLeft=0", dones, gntQ.size());
        end
        doReset();
    endtask

    task automatic test_late_req;
        exp_t e;
        int gntCycle;
        int doneCycle;
        useFixed = 1'b1;
        fixedData = 32'hCAFE_F00D;
        ifcA.addr0 = 32'h300; ifcA.we0 = 1'b0; ifcA.req0 = 1'b1;
        doneQ.push_back('{1'b0, 32'hCAFE_F00D});
        gntCycle = -1;
        doneCycle = -1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (ifcA.gnt1 && gntCycle < 0) gntCycle = c;
            if (ifcA.done0 || ifcA.done1) begin
                total++;
                if (ifcA.done0) begin
                    doneCycle = c;
                    ifcA.req0 = 1'b0;
                end else begin
                    ifcA.req1 = 1'b0;
                end
                if (doneQ.size() == 0) begin
                    bad++;
                    $display("[TB] FAIL late_extra_done got=%b want=none", {ifcA.done1, ifcA.done0});
                end else begin
                    e = doneQ.pop_front();
                    if ({ifcA.done1, ifcA.done0} !== {e.who, ~e.who} || ifcA.rdata !== e.data) begin
                        bad++;
                        $display("[TB] FAIL late_done done1,done0=%b rdata=%h want=%b rdata=%h",
                                 {ifcA.done1, ifcA.done0}, ifcA.rdata, {e.who, ~e.who}, e.data);
                    end
                end
            end
            if (c == 1) begin
                ifcA.addr1 = 32'h400; ifcA.we1 = 1'b1; ifcA.wdata1 = 32'h7777_0000; ifcA.req1 = 1'b1;
                doneQ.push_back('{1'b1, 32'hCAFE_F00D});
            end
        end
        total++;
        if (doneCycle != 3 || gntCycle != doneCycle + 1) begin
            bad++;
            $display("[TB] FAIL late_gnt1 doneCycle=%0d gnt1Cycle=%0d want 3 and 4", doneCycle, gntCycle);
        end
        total++;
        if (doneQ.size() != 0) begin
            bad++;
            $display("[TB] FAIL late_pending got=%0d want=0", doneQ.size());
        end
        doReset();
    endtask

    task automatic test_lat1;
        int enCount, gntCount, gapErr, overlapErr, altErr, lastGnt;
        logic prevWho, firstWho;
        enCount = 0; gntCount = 0; gapErr = 0; overlapErr = 0; altErr = 0; lastGnt = -1;
        prevWho = 1'b0; firstWho = 1'b1;
        ifcB.addr0 = 32'h500; ifcB.addr1 = 32'h600;
        ifcB.req0 = 1'b1; ifcB.req1 = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (ifcB.mem_en) enCount++;
            if ((ifcB.gnt0 && ifcB.done0) || (ifcB.gnt1 && ifcB.done1)) overlapErr++;
            if (ifcB.gnt0 || ifcB.gnt1) begin
                gntCount++;
                if (lastGnt < 0) firstWho = ifcB.gnt1;
                else begin
                    if (c - lastGnt != 2) gapErr++;
                    if (ifcB.gnt1 == prevWho) altErr++;
                end
                prevWho = ifcB.gnt1;
                lastGnt = c;
            end
        end
        ifcB.req0 = 1'b0; ifcB.req1 = 1'b0;
        total++;
        if (gntCount != 10 || gapErr != 0) begin
            bad++;
            $display("[TB] FAIL lat1_gnt_rate grants=%0d gapErr=%0d want 10 and 0", gntCount, gapErr);
        end
        total++;
        if (enCount != 10) begin
            bad++;
            $display("[TB] FAIL lat1_en_duty got=%0d want=10", enCount);
        end
        total++;
        if (overlapErr != 0 || altErr != 0 || firstWho !== 1'b0) begin
            bad++;
            $display("[TB] FAIL lat1_order overlap=%0d altErr=%0d first=%b want 0 0 0", overlapErr, altErr, firstWho);
        end
        doReset();
    endtask

    initial begin
        total = 0;
        bad = 0;
        useFixed = 1'b0;
        fixedData = '0;
        reset = 1'b1;
        clearInputs();
        test_reset();
        test_read();
        test_write();
        test_reset_mid_busy();
        test_alternate();
        test_late_req();
        test_lat1();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
